// File: rtl/prbs_source_pkg.sv
// Shared constants for the multi-channel PRBS source: polynomial taps,
// seeds, mode encoding and the counter saturation helper.
package prbs_source_pkg;

   // Fibonacci recurrences: b[n] = b[n-LEN] ^ b[n-TAP]
   localparam int PRBS31_LEN = 31;
   localparam int PRBS31_TAP = 28;
   localparam int PRBS7_LEN  = 7;
   localparam int PRBS7_TAP  = 6;

   // LFSR state holds the next LEN bits to be sent, so the seed is emitted first
   localparam logic [PRBS31_LEN-1:0] PRBS31_SEED = '1;
   localparam logic [PRBS7_LEN-1:0]  PRBS7_SEED  = '1;

   localparam logic MODE_PRBS31 = 1'b0;
   localparam logic MODE_PRBS7  = 1'b1;

   function automatic longint unsigned sat_val(input int unsigned cnt_w);
      return (64'd1 << cnt_w) - 64'd1;
   endfunction

endpackage

// File: rtl/prbs_source_mc_lane.sv
// One PRBS lane: word-parallel LFSR, mode tracking, single-bit error
// injection and saturating injected-error counter. All outputs registered.
// PRBS_SOURCE_PRBS7_EN: when defined, adds the PRBS7 generator and honours
// prbs_mode; otherwise the lane is PRBS31-only and prbs_mode is ignored.
module prbs_lane
   import prbs_source_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              prbs_mode,
   input  logic              inj_enable,
   input  logic [15:0]       inj_period,
   input  logic              inj_clear,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic [CNT_W-1:0]  inj_count
);

   localparam int               POS_W    = $clog2(DATA_W);
   localparam int               EXT31_W  = DATA_W + PRBS31_LEN;
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(sat_val(CNT_W));
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_W - 1);

   // Extends the state by DATA_W bits; low DATA_W bits are the word, the rest is the next state
   function automatic logic [EXT31_W-1:0] prbs31_ext(input logic [PRBS31_LEN-1:0] s);
      logic [EXT31_W-1:0] e;
      e = '0;
      e[PRBS31_LEN-1:0] = s;
      for (int j = PRBS31_LEN; j < EXT31_W; j++) e[j] = e[j-PRBS31_LEN] ^ e[j-PRBS31_TAP];
      return e;
   endfunction

   logic [PRBS31_LEN-1:0] lfsr31_q, lfsr31_d;
   logic [EXT31_W-1:0]    ext31;
   logic [DATA_W-1:0]     word_raw;
   logic [DATA_W-1:0]     inj_mask;
   logic                  mode_chg;
   logic                  inj_armed;
   logic                  inj_hit;
   logic [15:0]           per_cnt_q, per_cnt_d;
   logic [POS_W-1:0]      inj_pos_q, inj_pos_d;
   logic [CNT_W-1:0]      inj_cnt_q, inj_cnt_d;
   logic [DATA_W-1:0]     tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;

   assign ext31 = prbs31_ext(lfsr31_q);

`ifdef PRBS_SOURCE_PRBS7_EN
   localparam int EXT7_W = DATA_W + PRBS7_LEN;

   function automatic logic [EXT7_W-1:0] prbs7_ext(input logic [PRBS7_LEN-1:0] s);
      logic [EXT7_W-1:0] e;
      e = '0;
      e[PRBS7_LEN-1:0] = s;
      for (int j = PRBS7_LEN; j < EXT7_W; j++) e[j] = e[j-PRBS7_LEN] ^ e[j-PRBS7_TAP];
      return e;
   endfunction

   logic [PRBS7_LEN-1:0] lfsr7_q, lfsr7_d;
   logic [EXT7_W-1:0]    ext7;
   logic                 mode_q, mode_d;

   assign ext7     = prbs7_ext(lfsr7_q);
   // a mode edge costs one cycle: both generators reseed and no word is sent
   assign mode_chg = (prbs_mode != mode_q);
   assign word_raw = (mode_q == MODE_PRBS7) ? ext7[DATA_W-1:0] : ext31[DATA_W-1:0];
`else
   logic unused_mode;
   assign unused_mode = prbs_mode;
   assign mode_chg    = 1'b0;
   assign word_raw    = ext31[DATA_W-1:0];
`endif

   // >= rather than == so that shrinking inj_period below the running count injects at once
   assign inj_armed = inj_enable && (inj_period != 16'd0);
   assign inj_hit   = enable && !mode_chg && inj_armed && (per_cnt_q >= inj_period - 16'd1);
   assign inj_mask  = DATA_W'(1) << inj_pos_q;

   // Next-state: generator advance, injection bookkeeping, lock-up guard, clear
   always_comb begin
      lfsr31_d   = lfsr31_q;
`ifdef PRBS_SOURCE_PRBS7_EN
      lfsr7_d    = lfsr7_q;
      mode_d     = prbs_mode;
`endif
      per_cnt_d  = per_cnt_q;
      inj_pos_d  = inj_pos_q;
      inj_cnt_d  = inj_cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;

      if (mode_chg) begin
         lfsr31_d = PRBS31_SEED;
`ifdef PRBS_SOURCE_PRBS7_EN
         lfsr7_d  = PRBS7_SEED;
`endif
      end else if (enable) begin
         tx_valid_d = 1'b1;
         tx_data_d  = inj_hit ? (word_raw ^ inj_mask) : word_raw;
`ifdef PRBS_SOURCE_PRBS7_EN
         if (mode_q == MODE_PRBS7) lfsr7_d = ext7[DATA_W +: PRBS7_LEN];
         else                      lfsr31_d = ext31[DATA_W +: PRBS31_LEN];
`else
         lfsr31_d = ext31[DATA_W +: PRBS31_LEN];
`endif
         if (inj_hit) begin
            per_cnt_d = '0;
            inj_pos_d = (inj_pos_q == POS_LAST) ? '0 : inj_pos_q + 1'b1;
            if (inj_cnt_q != CNT_SAT) inj_cnt_d = inj_cnt_q + 1'b1;
         end else if (inj_armed) begin
            per_cnt_d = per_cnt_q + 16'd1;
         end
      end

      if (lfsr31_q == '0) lfsr31_d = PRBS31_SEED;
`ifdef PRBS_SOURCE_PRBS7_EN
      if (lfsr7_q == '0) lfsr7_d = PRBS7_SEED;
`endif

      // clear wins over a coincident increment; the word itself stays corrupted
      if (inj_clear) begin
         per_cnt_d = '0;
         inj_pos_d = '0;
         inj_cnt_d = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr31_q   <= PRBS31_SEED;
`ifdef PRBS_SOURCE_PRBS7_EN
         lfsr7_q    <= PRBS7_SEED;
         mode_q     <= MODE_PRBS31;
`endif
         per_cnt_q  <= '0;
         inj_pos_q  <= '0;
         inj_cnt_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         lfsr31_q   <= lfsr31_d;
`ifdef PRBS_SOURCE_PRBS7_EN
         lfsr7_q    <= lfsr7_d;
         mode_q     <= mode_d;
`endif
         per_cnt_q  <= per_cnt_d;
         inj_pos_q  <= inj_pos_d;
         inj_cnt_q  <= inj_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign inj_count = inj_cnt_q;

endmodule

// File: rtl/prbs_source_mc.sv
// Multi-channel PRBS pattern source: NUM_CH independent lanes sharing the
// injection period and clear. PRBS_SOURCE_PRBS7_EN enables per-lane PRBS7.
module prbs_source_mc
   import prbs_source_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        enable,
   input  logic [NUM_CH-1:0]        prbs_mode,
   input  logic [NUM_CH-1:0]        inj_enable,
   input  logic [15:0]              inj_period,
   input  logic                     inj_clear,
   output logic [NUM_CH*DATA_W-1:0] tx_data,
   output logic [NUM_CH-1:0]        tx_valid,
   output logic [NUM_CH*CNT_W-1:0]  inj_count
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      prbs_lane #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .clk        (clk),
         .reset_n    (reset_n),
         .enable     (enable[i]),
         .prbs_mode  (prbs_mode[i]),
         .inj_enable (inj_enable[i]),
         .inj_period (inj_period),
         .inj_clear  (inj_clear),
         .tx_data    (tx_data[DATA_W*i +: DATA_W]),
         .tx_valid   (tx_valid[i]),
         .inj_count  (inj_count[CNT_W*i +: CNT_W])
      );
   end

endmodule

// File: tb/tb_prbs_source_mc.sv
// Scoreboard bench for prbs_source_mc. The reference model produces each
// lane's bit stream from the recurrence one bit at a time and applies the
// injection rules per word; a negedge monitor pops and compares.
module tb_prbs_source_mc;

   localparam int NUM_CH = 8;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int SAT    = 15;
`ifdef PRBS_SOURCE_PRBS7_EN
   localparam bit P7 = 1'b1;
`else
   localparam bit P7 = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_CH-1:0]        enable;
   logic [NUM_CH-1:0]        prbs_mode;
   logic [NUM_CH-1:0]        inj_enable;
   logic [15:0]              inj_period;
   logic                     inj_clear;
   logic [NUM_CH*DATA_W-1:0] tx_data;
   logic [NUM_CH-1:0]        tx_valid;
   logic [NUM_CH*CNT_W-1:0]  inj_count;

   prbs_source_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .prbs_mode  (prbs_mode),
      .inj_enable (inj_enable),
      .inj_period (inj_period),
      .inj_clear  (inj_clear),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .inj_count  (inj_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   exp_t        exp_q[NUM_CH][$];
   bit          hist[NUM_CH][$];
   int unsigned nbits[NUM_CH];
   bit          m_mode[NUM_CH];
   int          m_pc[NUM_CH];
   int          m_pos[NUM_CH];
   int          m_cnt[NUM_CH];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // next stream bit: seed ones first, then b[n] = b[n-L] ^ b[n-T]
   function automatic bit next_bit(input int ln, input bit m);
      int l;
      int t;
      bit b;
      l = m ? 7 : 31;
      t = m ? 6 : 28;
      if (nbits[ln] < l) b = 1'b1;
      else b = hist[ln][hist[ln].size()-l] ^ hist[ln][hist[ln].size()-t];
      hist[ln].push_back(b);
      if (hist[ln].size() > 31) void'(hist[ln].pop_front());
      nbits[ln]++;
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         hist[i].delete();
         exp_q[i].delete();
         nbits[i]  = 0;
         m_mode[i] = 1'b0;
         m_pc[i]   = 0;
         m_pos[i]  = 0;
         m_cnt[i]  = 0;
      end
   endtask

   // Predict what the coming rising edge does with the current inputs
   task automatic model_step();
      for (int i = 0; i < NUM_CH; i++) begin
         bit                m;
         bit                push;
         logic [DATA_W-1:0] w;
         exp_t              e;
         m    = P7 ? prbs_mode[i] : 1'b0;
         push = 1'b0;
         w    = '0;
         if (m != m_mode[i]) begin
            m_mode[i] = m;
            hist[i].delete();
            nbits[i] = 0;
         end else if (enable[i]) begin
            push = 1'b1;
            for (int k = 0; k < DATA_W; k++) w[k] = next_bit(i, m);
            if (inj_enable[i] && inj_period != 16'd0) begin
               if (m_pc[i] >= int'(inj_period) - 1) begin
                  w[m_pos[i]] = ~w[m_pos[i]];
                  m_pc[i]  = 0;
                  m_pos[i] = (m_pos[i] + 1) % DATA_W;
                  if (m_cnt[i] < SAT) m_cnt[i]++;
               end else begin
                  m_pc[i]++;
               end
            end
         end
         if (inj_clear) begin
            m_cnt[i] = 0;
            m_pc[i]  = 0;
            m_pos[i] = 0;
         end
         if (push) begin
            e.data = w;
            e.cnt  = CNT_W'(m_cnt[i]);
            exp_q[i].push_back(e);
         end
      end
   endtask

   // inputs are set at a negedge, then tick predicts the edge and moves on
   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic check_counts(input string name, input int req);
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("%s lane%0d", name, i), 256'(inj_count[CNT_W*i +: CNT_W]), 256'(req));
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst tx_data", tx_data, '0);
      chk("rst tx_valid", 256'(tx_valid), '0);
      chk("rst inj_count", 256'(inj_count), '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor: every presented word must match the oldest prediction for its lane
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (tx_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL lane%0d unexpected word actual=%0h required=none", i,
                           tx_data[DATA_W*i +: DATA_W]);
               end else begin
                  e = exp_q[i].pop_front();
                  chk($sformatf("lane%0d data", i), 256'(tx_data[DATA_W*i +: DATA_W]), 256'(e.data));
                  chk($sformatf("lane%0d count", i), 256'(inj_count[CNT_W*i +: CNT_W]), 256'(e.cnt));
               end
            end
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      enable     = '1;
      prbs_mode  = '0;
      inj_enable = '0;
      inj_period = 16'd0;
      inj_clear  = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset tx_data", tx_data, '0);
      chk("reset tx_valid", 256'(tx_valid), '0);
      chk("reset inj_count", 256'(inj_count), '0);
      reset_n = 1'b1;

      // first two PRBS31 words from the all-ones seed
      tick();
      chk("first valid", 256'(tx_valid), 256'({NUM_CH{1'b1}}));
      chk("word0", tx_data, {NUM_CH{32'h7FFF_FFFF}});
      tick();
      chk("word1", tx_data, {NUM_CH{32'h3800_0000}});

      // long PRBS31 run with a 10-cycle hold on lane 5
      ticks(5000);
      enable[5] = 1'b0;
      ticks(10);
      enable[5] = 1'b1;
      ticks(5000);

      // injection every 4th word
      inj_clear = 1'b1;
      tick();
      inj_clear  = 1'b0;
      inj_enable = '1;
      inj_period = 16'd4;
      ticks(40);
      check_counts("period4 count", 10);

      // saturation, then clear on an injecting word
      inj_clear = 1'b1;
      tick();
      inj_clear  = 1'b0;
      inj_period = 16'd1;
      ticks(20);
      check_counts("saturated count", SAT);
      inj_clear = 1'b1;
      tick();
      inj_clear = 1'b0;
      check_counts("clear on inject", 0);

      // period shrinks below the running count
      inj_period = 16'd5;
      ticks(3);
      inj_period = 16'd2;
      ticks(6);

      // mode switch on lane 2 (no effect unless PRBS7 is built)
      inj_enable   = '0;
      prbs_mode[2] = 1'b1;
      ticks(260);
      prbs_mode[2] = 1'b0;
      ticks(20);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         enable = NUM_CH'($urandom() | $urandom());
         if ($urandom_range(0, 19) == 0) inj_enable = NUM_CH'($urandom());
         if ($urandom_range(0, 39) == 0) inj_period = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 29) == 0) prbs_mode = prbs_mode ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH-1));
         inj_clear = ($urandom_range(0, 49) == 0);
         tick();
      end
      inj_clear = 1'b0;

      // asynchronous reset mid-stream, then restart from the seed
      do_reset();
      enable    = '1;
      prbs_mode = '0;
      tick();
      chk("restart word0", tx_data, {NUM_CH{32'h7FFF_FFFF}});
      ticks(50);

      // drain and confirm every prediction was consumed
      enable = '0;
      ticks(3);
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("lane%0d leftover", i), 256'(exp_q[i].size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs_source_mc.md
# prbs_source_mc

Multi-channel parametrised PRBS pattern source for the GBCR SEU test firmware. It drives parallel words to the transceiver TX data inputs, one lane per channel, all in a single clock domain. Each lane generates PRBS7 or PRBS31, selectable at run time per channel. Each lane can inject single-bit errors at a programmable word period and counts them in a saturating counter that software reads back for comparison with the receiver-side checker.

## Interface
- NUM_CH, 8, number of channels/lanes
- DATA_W, 32, parallel word width per lane (≥ 8)
- CNT_W, 16, width of each injected-error counter
- clk  in  1  TX user clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-lane run enable
- prbs_mode  in  NUM_CH  per-lane mode: 0 = PRBS31 (x^31+x^28+1), 1 = PRBS7 (x^7+x^6+1)
- inj_enable  in  NUM_CH  per-lane error-injection enable
- inj_period  in  16  words between injections, shared by all lanes; 0 = no injection
- inj_clear  in  1  synchronous pulse; clears all counters and period counters
- tx_data  out  NUM_CH*DATA_W  lane i at [DATA_W*i +: DATA_W]
- tx_valid  out  NUM_CH  lane produced a new word this cycle
- inj_count  out  NUM_CH*CNT_W  lane i at [CNT_W*i +: CNT_W]; saturating

## Operation
- Bit order: stream bit index n = w*DATA_W + k maps to word w, tx_data bit k. Bit 0 is the first bit transmitted.
- Stream law, uncorrupted: PRBS31 b[n] = b[n-31] ^ b[n-28]; PRBS7 b[n] = b[n-7] ^ b[n-6].
- Each lane advances its LFSR by DATA_W bits per cycle when enable[i]=1, computed as an unrolled combinational step.
- When enable[i]=0, the LFSR, tx_data and the period counter hold, and tx_valid[i]=0.
- Seed is all-ones for the active mode.
- Lock-up guard: if the active LFSR state is all zero, reload the seed on the next cycle.
- A change of prbs_mode[i] is detected against a registered copy. The lane reseeds in that cycle. The next valid word starts the new sequence from the seed.
- Injection, per lane:
  - The period counter increments on each valid word while inj_enable[i]=1 and inj_period≠0.
  - When it equals inj_period-1, the outgoing word has bit inj_pos[i] inverted, the period counter returns to 0, and inj_count[i] increments unless it is saturated at 2^CNT_W-1.
  - inj_pos[i] starts at 0 and increments after each injection, wrapping from DATA_W-1 to 0.
  - inj_period=1 injects into every word.
- Injection corrupts the output only. The LFSR state is never altered.
- Dropping inj_enable[i] holds the period counter and inj_pos[i]. They are not cleared.
- inj_clear zeroes inj_count, the period counters and inj_pos for all lanes.
  - If inj_clear coincides with an injection, clear wins: count = 0 after the edge. The word is still corrupted.
- A change of inj_period takes effect on the next valid word. If the period counter is already ≥ the new inj_period-1, the next valid word injects.

## Timing
- Output is fully registered. tx_data and tx_valid appear one cycle after the enable-qualified clock edge.
- First valid word appears the cycle after enable[i] rises. It is the first DATA_W bits from the seed.
- inj_count updates in the same cycle as the corrupted word appears on tx_data.
- Reset values:
  - tx_data = 0, tx_valid = 0, inj_count = 0.
  - LFSRs hold the all-ones seed. Period counters = 0, inj_pos = 0.
  - The mode register holds prbs_mode's reset value, 0.
- Reset mid-stream: outputs drop to reset values immediately (asynchronously). After release, a lane with enable=1 restarts from the seed on the first edge.
- Lanes are independent. No cross-lane timing dependency exists except the shared inj_period and inj_clear.

## Configuration
- PRBS_SOURCE_PRBS7_EN defined: PRBS7 hardware is built, and prbs_mode selects per lane as above.
- Not defined: PRBS7 logic is omitted, prbs_mode is ignored, every lane runs PRBS31, and mode-change reseeding never occurs. The port list is unchanged.

## Structure
- Package prbs_source_pkg holds:
  - polynomial tap constants for PRBS31 and PRBS7;
  - seed constants;
  - mode encoding constants MODE_PRBS31 = 0 and MODE_PRBS7 = 1;
  - the saturation-value function for CNT_W.
- Sub-module prbs_lane: one channel's LFSR(s), mode tracking, period counter, inj_pos, saturating counter and output registers. The top instantiates NUM_CH copies with a generate loop and concatenates the buses.

## Test plan
- Reset: assert reset_n=0 with enable all-ones → tx_data=0, tx_valid=0, inj_count=0. Release → first tx_valid one cycle after the first edge.
- PRBS7, DATA_W=32: run 254 words → words w and w+127 are identical, and the stream law holds on all bits.
- PRBS31: run 10000 words on all 8 lanes → zero stream-law violations. Lanes are bit-identical because they share a seed.
- Injection: inj_period=4, inj_enable=1 for 100 words → inj_count=25. Every 4th word differs from the reference model in exactly one bit, at positions 0,1,2,… in order.
- Saturation and clear: CNT_W=4, inj_period=1, 20 words → inj_count=15. Then pulse inj_clear on an injecting cycle → inj_count=0, and that word is still corrupted.
- Mode switch and hold:
  - Toggle prbs_mode[2] from 0 to 1 mid-run → the next valid word on lane 2 is the PRBS7 seed word. Other lanes are unaffected.
  - Drop enable[5] for 10 cycles → lane 5 resumes with the next sequence word, and no bits are skipped.
